// File: rtl/seq_detect_pkg.sv
// Shared types and constants for the programmable serial-pattern detector.
package seq_detect_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READY = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int MIN_LEN = 2;

    // Width needed to hold a pattern length in 0..maxLen.
    function automatic int LEN_W(input int maxLen);
        return $clog2(maxLen + 1);
    endfunction

endpackage

// File: rtl/seq_detect_ctrl_window.sv
// Sliding bit history with fill tracking and a length-masked compare.
// match_o reflects the history as it will be once the current bit is shifted in.
module seq_window_match
    import seq_detect_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int LenW    = LEN_W(MAX_LEN)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               shift_en_i,
    input  logic               clear_i,
    input  logic               bit_i,
    input  logic [MAX_LEN-1:0] pattern_i,
    input  logic [LenW-1:0]    len_i,
    output logic               match_o
);

    logic [MAX_LEN-1:0] history_q;
    logic [MAX_LEN-1:0] history_d;
    logic [LenW-1:0]    fill_q;
    logic [LenW-1:0]    fill_d;
    logic [MAX_LEN-1:0] lenMask;

    always_comb begin
        history_d = {history_q[MAX_LEN-2:0], bit_i};
        fill_d    = (fill_q == LenW'(MAX_LEN)) ? fill_q : fill_q + LenW'(1);
        lenMask   = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            lenMask[i] = (i < int'(len_i));
        end
        // Only the newest len bits take part; older history is don't-care.
        match_o = shift_en_i && !clear_i && (fill_d >= len_i) &&
                  (((history_d ^ pattern_i) & lenMask) == '0);
    end

    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            history_q <= '0;
            fill_q    <= '0;
        end else if (shift_en_i) begin
            history_q <= history_d;
            fill_q    <= fill_d;
        end
    end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Run-time configurable overlapping pattern detector with a config handshake,
// a saturating match counter and an optional auto-stop target.
module seq_detect_ctrl
    import seq_detect_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    localparam int LenW   = LEN_W(MAX_LEN)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LenW-1:0]    cfg_len,
    input  logic [CNT_W-1:0]   cfg_target,
    output logic               cfg_err,
    input  logic               start,
    input  logic               abort,
    input  logic               a,
    input  logic               a_valid,
    output logic               detected,
    output logic [CNT_W-1:0]   match_count,
    output logic               busy,
    output logic               done
);

    state_e             state_q;
    logic [MAX_LEN-1:0] cfgPattern_q;
    logic [LenW-1:0]    cfgLen_q;
    logic [CNT_W-1:0]   cfgTarget_q;
    logic [CNT_W-1:0]   matchCount_q;
    logic [CNT_W-1:0]   matchCount_d;
    logic               detected_q;
    logic               cfgErr_q;

    logic cfgAccept;
    logic cfgLegal;
    logic runEntry;
    logic shiftEn;
    logic windowMatch;
    logic targetHit;

    always_comb begin
        cfgAccept    = cfg_valid && (state_q != RUN);
        cfgLegal     = (cfg_len >= LenW'(MIN_LEN)) && (cfg_len <= LenW'(MAX_LEN));
        // Any config beat in READY/DONE takes priority over a simultaneous start.
        runEntry     = start && !cfg_valid && ((state_q == READY) || (state_q == DONE));
        shiftEn      = (state_q == RUN) && a_valid;
        matchCount_d = (matchCount_q == '1) ? matchCount_q : matchCount_q + CNT_W'(1);
        targetHit    = (cfgTarget_q != '0) && (matchCount_d == cfgTarget_q);
    end

    seq_window_match #(
        .MAX_LEN (MAX_LEN),
        .LenW    (LenW)
    ) u_window (
        .clk        (clk),
        .rst        (rst),
        .shift_en_i (shiftEn),
        .clear_i    (runEntry),
        .bit_i      (a),
        .pattern_i  (cfgPattern_q),
        .len_i      (cfgLen_q),
        .match_o    (windowMatch)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cfgPattern_q <= '0;
            cfgLen_q     <= '0;
            cfgTarget_q  <= '0;
            matchCount_q <= '0;
            detected_q   <= 1'b0;
            cfgErr_q     <= 1'b0;
        end else begin
            detected_q <= 1'b0;
            cfgErr_q   <= 1'b0;
            case (state_q)
                IDLE, READY, DONE: begin
                    if (cfgAccept) begin
                        if (cfgLegal) begin
                            cfgPattern_q <= cfg_pattern;
                            cfgLen_q     <= cfg_len;
                            cfgTarget_q  <= cfg_target;
                            state_q      <= READY;
                        end else begin
                            cfgErr_q <= 1'b1;
                        end
                    end else if (runEntry) begin
                        matchCount_q <= '0;
                        state_q      <= RUN;
                    end
                end
                RUN: begin
                    // Abort discards a match completing on the same beat.
                    if (abort) begin
                        state_q <= READY;
                    end else if (windowMatch) begin
                        detected_q   <= 1'b1;
                        matchCount_q <= matchCount_d;
                        if (targetHit) begin
                            state_q <= DONE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cfg_ready   = (state_q != RUN);
    assign busy        = (state_q == RUN);
    assign done        = (state_q == DONE);
    assign detected    = detected_q;
    assign cfg_err     = cfgErr_q;
    assign match_count = matchCount_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed bench for seq_detect_ctrl: a bit-list reference model checked every
// cycle, plus literal expectations for each scenario.
module tb_seq_detect_ctrl;

    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 8;
    localparam int LW      = 4;

    logic               clk;
    logic               rst;
    logic               cfg_valid;
    logic               cfg_ready;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LW-1:0]      cfg_len;
    logic [CNT_W-1:0]   cfg_target;
    logic               cfg_err;
    logic               start;
    logic               abort;
    logic               a;
    logic               a_valid;
    logic               detected;
    logic [CNT_W-1:0]   match_count;
    logic               busy;
    logic               done;

    int checks = 0;
    int errors = 0;
    int pulses;

    seq_detect_ctrl #(
        .MAX_LEN (MAX_LEN),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_target  (cfg_target),
        .cfg_err     (cfg_err),
        .start       (start),
        .abort       (abort),
        .a           (a),
        .a_valid     (a_valid),
        .detected    (detected),
        .match_count (match_count),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: phases of the run and the list of bits seen since run start.
    localparam int P_IDLE = 0, P_READY = 1, P_RUN = 2, P_DONE = 3;
    int         mPhase;
    int         mLen;
    logic [7:0] mPat;
    int         mTarget;
    int         mCount;
    bit         mDet;
    bit         mErr;
    bit         mBits[$];
    bit         modelOn = 0;

    function automatic bit tailMatches();
        if (mBits.size() < mLen) return 0;
        for (int k = 0; k < mLen; k++) begin
            if (mBits[mBits.size() - 1 - k] != mPat[k]) return 0;
        end
        return 1;
    endfunction

    always @(posedge clk) begin
        mDet = 0;
        mErr = 0;
        if (rst) begin
            mPhase = P_IDLE; mLen = 0; mPat = 0; mTarget = 0; mCount = 0;
            mBits.delete();
        end else if (mPhase != P_RUN) begin
            if (cfg_valid) begin
                if (cfg_len >= 2 && cfg_len <= MAX_LEN) begin
                    mPat = cfg_pattern; mLen = cfg_len; mTarget = cfg_target;
                    mPhase = P_READY;
                end else begin
                    mErr = 1;
                end
            end else if (start && mPhase != P_IDLE) begin
                mPhase = P_RUN; mCount = 0;
                mBits.delete();
            end
        end else if (abort) begin
            mPhase = P_READY;
        end else if (a_valid) begin
            mBits.push_back(a);
            if (mBits.size() > 16) void'(mBits.pop_front());
            if (tailMatches()) begin
                mDet = 1;
                if (mCount < 255) mCount++;
                if (mTarget != 0 && mCount == mTarget) mPhase = P_DONE;
            end
        end
    end

    always @(negedge clk) begin
        if (modelOn) begin
            checkOutput("model_detected", detected, mDet);
            checkOutput("model_cfg_err", cfg_err, mErr);
            checkOutput("model_match_count", match_count, mCount);
            checkOutput("model_busy", busy, mPhase == P_RUN);
            checkOutput("model_done", done, mPhase == P_DONE);
            checkOutput("model_cfg_ready", cfg_ready, mPhase != P_RUN);
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] pat, input int len, input int tgt);
        cfg_pattern = pat;
        cfg_len     = LW'(len);
        cfg_target  = CNT_W'(tgt);
        cfg_valid   = 1'b1;
        cycle();
        cfg_valid   = 1'b0;
    endtask

    task automatic doStart();
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic doReset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    // Sends n bits, first bit = bits[n-1]; expDet uses the same ordering.
    task automatic sendBits(input logic [15:0] bits, input int n, input logic [15:0] expDet);
        for (int i = n - 1; i >= 0; i--) begin
            a       = bits[i];
            a_valid = 1'b1;
            cycle();
            checkOutput($sformatf("detected_bit%0d", n - i), detected, expDet[i]);
        end
        a_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cfg_valid = 0; cfg_pattern = 0; cfg_len = 0; cfg_target = 0;
        start = 0; abort = 0; a = 0; a_valid = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        modelOn = 1;

        $display("[TB] reset values");
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_count", match_count, 0);
        checkOutput("reset_cfg_ready", cfg_ready, 1);

        $display("[TB] 110011 overlapping, unlimited target");
        applyStimulus(8'b0011_0011, 6, 0);
        doStart();
        checkOutput("t1_busy_after_start", busy, 1);
        sendBits(16'b11_0011_0011, 10, 16'b00_0001_0001);
        checkOutput("t1_count", match_count, 2);
        checkOutput("t1_busy", busy, 1);
        abort = 1'b1; cycle(); abort = 1'b0;
        checkOutput("t1_abort_busy", busy, 0);

        $display("[TB] 1010 with target 3");
        applyStimulus(8'b0000_1010, 4, 3);
        doStart();
        sendBits(16'b1010_1010, 8, 16'b0001_0101);
        checkOutput("t2_done", done, 1);
        checkOutput("t2_busy", busy, 0);
        checkOutput("t2_count", match_count, 3);
        sendBits(16'b10, 2, 16'b00);
        checkOutput("t2_count_hold", match_count, 3);

        $display("[TB] illegal lengths");
        doReset();
        applyStimulus(8'b0000_0001, 1, 0);
        checkOutput("t3_err_len1", cfg_err, 1);
        cycle();
        checkOutput("t3_err_clear", cfg_err, 0);
        checkOutput("t3_ready", cfg_ready, 1);
        applyStimulus(8'b1111_1111, MAX_LEN + 1, 0);
        checkOutput("t3_err_len9", cfg_err, 1);
        doStart();
        checkOutput("t3_still_idle", busy, 0);

        $display("[TB] cfg during run, abort on match");
        applyStimulus(8'b0011_0011, 6, 0);
        doStart();
        cfg_pattern = 8'b0000_1010; cfg_len = 4; cfg_valid = 1'b1;
        #1;
        checkOutput("t4_cfg_ready_run", cfg_ready, 0);
        sendBits(16'b11_0011, 6, 16'b00_0001);
        cfg_valid = 1'b0;
        checkOutput("t4_count", match_count, 1);
        sendBits(16'b001, 3, 16'b000);
        a = 1'b1; a_valid = 1'b1; abort = 1'b1;
        cycle();
        a_valid = 1'b0; abort = 1'b0;
        checkOutput("t4_abort_det", detected, 0);
        checkOutput("t4_abort_count", match_count, 1);
        checkOutput("t4_abort_busy", busy, 0);

        $display("[TB] cfg and start together");
        cfg_pattern = 8'b0000_1011; cfg_len = 4; cfg_target = 2;
        cfg_valid = 1'b1; start = 1'b1;
        cycle();
        cfg_valid = 1'b0; start = 1'b0;
        checkOutput("t5_busy_cfg_wins", busy, 0);
        doStart();
        checkOutput("t5_busy", busy, 1);
        checkOutput("t5_count_cleared", match_count, 0);
        sendBits(16'b101_1011, 7, 16'b000_1001);
        checkOutput("t5_done", done, 1);

        $display("[TB] gaps in a_valid, then reset mid-run");
        applyStimulus(8'b0011_0011, 6, 0);
        doStart();
        pulses = 0;
        for (int i = 5; i >= 0; i--) begin
            logic [5:0] gapBits;
            gapBits = 6'b110011;
            a = gapBits[i]; a_valid = 1'b1;
            cycle();
            pulses += int'(detected);
            a = ~gapBits[i]; a_valid = 1'b0;
            cycle();
            pulses += int'(detected);
        end
        checkOutput("t6_single_pulse", pulses, 1);
        sendBits(16'b10, 2, 16'b00);
        doReset();
        checkOutput("t6_rst_busy", busy, 0);
        checkOutput("t6_rst_count", match_count, 0);
        checkOutput("t6_rst_ready", cfg_ready, 1);
        doStart();
        checkOutput("t6_rst_no_run", busy, 0);

        $display("[TB] full-length pattern");
        applyStimulus(8'b1011_0010, MAX_LEN, 0);
        doStart();
        sendBits(16'b1011_0010, 8, 16'b0000_0001);
        abort = 1'b1; cycle(); abort = 1'b0;

        $display("[TB] counter saturation with minimum length");
        applyStimulus(8'b0000_0011, 2, 0);
        doStart();
        a = 1'b1; a_valid = 1'b1;
        repeat (300) cycle();
        a_valid = 1'b0;
        checkOutput("t7_saturated", match_count, 255);
        checkOutput("t7_busy", busy, 1);

        cycle();
        modelOn = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
